lfsr_prng: RTL and testbench
============================

# lfsr_prng

Parametrised Fibonacci LFSR pseudo-random source with a valid/ready draw handshake, seed loading and zero-state protection. It generalises the fixed 16-bit stage-random generator to any width and tap set. It adds synchronous reset and a one-value-per-request draw protocol, so downstream pattern logic (LED pattern builder, stage sequencer) can consume values at its own pace. Between draws the register free-runs every cycle, so the draw instant adds entropy from user timing.

## Interface
- WIDTH, 16: LFSR and output width; legal range 3..32.
- TAPS, 16'hB400: feedback mask; bit i set means state[i] is XORed into feedback (default = bits 15,13,12,10).
- SEED, 16'hACE1: reset value, and the substitute for any all-zero load; must be non-zero.
- clk  in  1  clock. Everything updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- seed_load  in  1  load seed_in into the state this cycle.
- seed_in  in  WIDTH  seed value.
- req  in  1  draw request, level. Its rising edge triggers one draw.
- rand_out  out  WIDTH  current LFSR state (live while running, frozen while holding).
- out_valid  out  1  rand_out holds a drawn value.
- out_ready  in  1  consumer accepts the drawn value.
- draw_cnt  out  16  count of accepted draws; wraps at 65535 -> 0.

## Operation
- Step function: next = {state[WIDTH-2:0], ^(state & TAPS)}. If state == 0, next = SEED (lock-up guard).
- FSM states:
  - RUN: steps every cycle. A req rising edge (req & ~req_q) steps once more, freezes the state and goes to HOLD.
  - HOLD: out_valid=1, state frozen. On out_valid & out_ready, go to RUN.
- Draws are one per req edge. Holding req high across an accept does not start a new draw; req must drop and rise again.
- seed_load, in any state:
  - state <= (seed_in == 0) ? SEED : seed_in; FSM -> RUN; out_valid -> 0.
  - Any pending draw is discarded and draw_cnt is unchanged.
- Priority: rst > seed_load > req edge / handshake. A req edge coincident with seed_load is dropped.
- draw_cnt increments by 1 on each accepted handshake (out_valid & out_ready).

## Timing
- Reset values: state/rand_out = SEED, out_valid = 0, draw_cnt = 0, req_q = 0, FSM = RUN.
- Draw latency:
  - req edge sampled at edge t gives out_valid=1 at t+1, with rand_out = step(state at t).
  - Accept at edge u (out_ready high): out_valid=0 at u+1 and free-running resumes the same cycle (rand_out = step of the held value at u+1).
- out_ready while out_valid=0 is ignored.
- rand_out and out_valid are registered outputs with no combinational path from inputs.
- rst asserted mid-HOLD: all outputs take their reset values at the next edge, and the pending draw is lost.

## Structure
- Shared package lfsr_pkg holds:
  - enum fsm_t {RUN, HOLD}.
  - Maximal-length tap constants: TAPS_8 = 8'hB8, TAPS_16 = 16'hB400, TAPS_32 = 32'h80200003.
- Sub-module lfsr_step: purely combinational, parametrised by WIDTH/TAPS/SEED, containing the next-state function and zero guard. lfsr_prng instantiates it once.
- Target size: about 150 lines of RTL.

## Test plan
- Reset and free-run, defaults: release rst -> rand_out = 16'hACE1, out_valid = 0. One cycle later rand_out = 16'h59C3.
- Back-pressure:
  - req rises with out_ready = 0 for 5 cycles -> out_valid = 1 from the next cycle and rand_out stable all 5 cycles.
  - out_ready = 1 -> out_valid = 0 next cycle and draw_cnt = 1.
- Level req: req held high through the accept and 10 more cycles -> exactly one draw.
- Re-arm: req low then high -> second draw, and draw_cnt = 2.
- Seeding:
  - seed_load with seed_in = 0 -> state = 16'hACE1.
  - seed_load with seed_in = 16'h0001 -> next cycle rand_out = 16'h0002.
- Abort: seed_load asserted while in HOLD -> out_valid = 0 next cycle, draw_cnt unchanged. Same-cycle req edge and seed_load -> no draw.
- Period, WIDTH = 8, TAPS = 8'hB8, SEED = 8'h01: free-run 255 cycles -> state returns to 8'h01, never reads 0, and all 255 non-zero values are seen.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and tap constants for the LFSR pseudo-random source.
package lfsr_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } fsm_t;

   // Maximal-length feedback masks for the left-shifting Fibonacci form.
   localparam logic [7:0]  TAPS_8  = 8'hB8;
   localparam logic [15:0] TAPS_16 = 16'hB400;
   localparam logic [31:0] TAPS_32 = 32'h80200003;

endpackage

// File: rtl/lfsr_prng_if.sv
// Draw/seed bundle between the LFSR source (slave) and its consumer (master).
interface lfsr_prng_if #(
   parameter int unsigned WIDTH = 16
) ();

   logic             seed_load;
   logic [WIDTH-1:0] seed_in;
   logic             req;
   logic [WIDTH-1:0] rand_out;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      draw_cnt;

   modport master (
      output seed_load, seed_in, req, out_ready,
      input  rand_out, out_valid, draw_cnt
   );

   modport slave (
      input  seed_load, seed_in, req, out_ready,
      output rand_out, out_valid, draw_cnt
   );

endinterface

// File: rtl/lfsr_step.sv
// Combinational next-state function of a Fibonacci LFSR with all-zero recovery.
module lfsr_step import lfsr_pkg::*; #(
   parameter int unsigned      WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = TAPS_16,
   parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
   input  logic [WIDTH-1:0] state_i,
   output logic [WIDTH-1:0] next_o
);

   logic feedback_s;

   // Shift left, feed the tap parity into bit 0; a zero state can never leave itself, so reseed.
   always_comb begin
      feedback_s = ^(state_i & TAPS);
      if (state_i == {WIDTH{1'b0}}) begin
         next_o = SEED;
      end else begin
         next_o = {state_i[WIDTH-2:0], feedback_s};
      end
   end

endmodule

// File: rtl/lfsr_prng.sv
// Free-running LFSR that freezes one value per request edge and hands it over with valid/ready.
module lfsr_prng import lfsr_pkg::*; #(
   parameter int unsigned      WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = TAPS_16,
   parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   lfsr_prng_if.slave  bus
);

   logic [WIDTH-1:0] state_q, state_d;
   logic [WIDTH-1:0] step_s;
   fsm_t             fsm_q, fsm_d;
   logic             out_valid_q, out_valid_d;
   logic [15:0]      draw_cnt_q, draw_cnt_d;
   logic             req_q, req_d;
   logic             req_edge_s;
   logic             accept_s;

   lfsr_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .SEED  (SEED)
   ) u_step (
      .state_i (state_q),
      .next_o  (step_s)
   );

   // Next-state selection: seeding overrides any draw activity and discards a pending value.
   always_comb begin
      state_d     = state_q;
      fsm_d       = fsm_q;
      out_valid_d = out_valid_q;
      draw_cnt_d  = draw_cnt_q;
      req_d       = bus.req;
      req_edge_s  = bus.req & ~req_q;
      accept_s    = out_valid_q & bus.out_ready;

      if (bus.seed_load) begin
         if (bus.seed_in == {WIDTH{1'b0}}) begin
            state_d = SEED;
         end else begin
            state_d = bus.seed_in;
         end
         fsm_d       = RUN;
         out_valid_d = 1'b0;
      end else begin
         case (fsm_q)
            RUN: begin
               state_d = step_s;
               if (req_edge_s) begin
                  fsm_d       = HOLD;
                  out_valid_d = 1'b1;
               end else begin
                  fsm_d       = RUN;
                  out_valid_d = 1'b0;
               end
            end
            HOLD: begin
               // Free-running resumes on the accept edge itself.
               if (accept_s) begin
                  state_d     = step_s;
                  fsm_d       = RUN;
                  out_valid_d = 1'b0;
                  draw_cnt_d  = draw_cnt_q + 16'd1;
               end else begin
                  state_d     = state_q;
                  fsm_d       = HOLD;
                  out_valid_d = 1'b1;
               end
            end
            default: begin
               state_d     = SEED;
               fsm_d       = RUN;
               out_valid_d = 1'b0;
            end
         endcase
      end
   end

   // State, FSM and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SEED;
         fsm_q       <= RUN;
         out_valid_q <= 1'b0;
         draw_cnt_q  <= 16'd0;
         req_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         fsm_q       <= fsm_d;
         out_valid_q <= out_valid_d;
         draw_cnt_q  <= draw_cnt_d;
         req_q       <= req_d;
      end
   end

   assign bus.rand_out  = state_q;
   assign bus.out_valid = out_valid_q;
   assign bus.draw_cnt  = draw_cnt_q;

endmodule

// File: tb/tb_lfsr_prng.sv
// Directed bench: default 16-bit draw protocol plus an 8-bit full-period instance.
module tb_lfsr_prng;
   import lfsr_pkg::*;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   logic [15:0] m;

   lfsr_prng_if #(.WIDTH(16)) bus16 ();
   lfsr_prng_if #(.WIDTH(8))  bus8 ();

   lfsr_prng u_dut16 (
      .clk (clk),
      .rst (rst),
      .bus (bus16)
   );

   lfsr_prng #(
      .WIDTH (8),
      .TAPS  (8'hB8),
      .SEED  (8'h01)
   ) u_dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] step16(input logic [15:0] s);
      if (s == 16'h0000) return 16'hACE1;
      return {s[14:0], ^(s & 16'hB400)};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests = n_tests + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic seen [256];
      int   n_seen;
      int   zero_hits;
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      bus16.seed_load = 1'b0; bus16.seed_in = 16'h0000; bus16.req = 1'b0; bus16.out_ready = 1'b0;
      bus8.seed_load  = 1'b0; bus8.seed_in  = 8'h00;    bus8.req  = 1'b0; bus8.out_ready  = 1'b0;
      tick();
      tick();
      check_eq("reset_rand", bus16.rand_out, 16'hACE1);
      check_eq("reset_valid", bus16.out_valid, 1'b0);
      check_eq("reset_cnt", bus16.draw_cnt, 16'd0);

      rst = 1'b0;
      tick();
      check_eq("first_step", bus16.rand_out, 16'h59C3);
      m = 16'h59C3;

      // Back-pressure: draw held for five cycles with out_ready low.
      bus16.req = 1'b1;
      tick();
      m = step16(m);
      for (int i = 0; i < 5; i++) begin
         check_eq("bp_valid", bus16.out_valid, 1'b1);
         check_eq("bp_rand", bus16.rand_out, m);
         if (i < 4) tick();
      end
      bus16.out_ready = 1'b1;
      tick();
      m = step16(m);
      check_eq("accept_valid", bus16.out_valid, 1'b0);
      check_eq("accept_cnt", bus16.draw_cnt, 16'd1);
      check_eq("accept_resume", bus16.rand_out, m);

      // Level req: held high with out_ready high must not draw again.
      for (int i = 0; i < 10; i++) begin
         tick();
         m = step16(m);
         check_eq("level_valid", bus16.out_valid, 1'b0);
      end
      check_eq("level_cnt", bus16.draw_cnt, 16'd1);
      check_eq("level_rand", bus16.rand_out, m);

      // Re-arm: second draw, accepted immediately since out_ready is high.
      bus16.req = 1'b0;
      tick();
      m = step16(m);
      bus16.req = 1'b1;
      tick();
      m = step16(m);
      check_eq("rearm_valid", bus16.out_valid, 1'b1);
      check_eq("rearm_rand", bus16.rand_out, m);
      tick();
      m = step16(m);
      check_eq("rearm_done", bus16.out_valid, 1'b0);
      check_eq("rearm_cnt", bus16.draw_cnt, 16'd2);
      bus16.req = 1'b0;
      bus16.out_ready = 1'b0;

      // Seeding, including the zero-seed substitution.
      bus16.seed_load = 1'b1; bus16.seed_in = 16'h0000;
      tick();
      check_eq("seed_zero", bus16.rand_out, 16'hACE1);
      bus16.seed_load = 1'b0;
      tick();
      check_eq("seed_zero_step", bus16.rand_out, 16'h59C3);
      bus16.seed_load = 1'b1; bus16.seed_in = 16'h0001;
      tick();
      check_eq("seed_one", bus16.rand_out, 16'h0001);
      bus16.seed_load = 1'b0;
      tick();
      check_eq("seed_one_step", bus16.rand_out, 16'h0002);

      // Abort a held draw by seeding.
      bus16.req = 1'b1;
      tick();
      check_eq("abort_hold_valid", bus16.out_valid, 1'b1);
      check_eq("abort_hold_rand", bus16.rand_out, 16'h0004);
      bus16.seed_load = 1'b1; bus16.seed_in = 16'h1234;
      tick();
      check_eq("abort_valid", bus16.out_valid, 1'b0);
      check_eq("abort_cnt", bus16.draw_cnt, 16'd2);
      check_eq("abort_rand", bus16.rand_out, 16'h1234);
      bus16.seed_load = 1'b0;
      tick();
      check_eq("abort_after_valid", bus16.out_valid, 1'b0);
      check_eq("abort_after_rand", bus16.rand_out, step16(16'h1234));

      // A request edge coincident with seed_load is dropped.
      bus16.req = 1'b0;
      tick();
      bus16.req = 1'b1; bus16.seed_load = 1'b1; bus16.seed_in = 16'h00FF;
      tick();
      check_eq("coinc_valid", bus16.out_valid, 1'b0);
      check_eq("coinc_rand", bus16.rand_out, 16'h00FF);
      bus16.seed_load = 1'b0;
      tick();
      check_eq("coinc_no_draw", bus16.out_valid, 1'b0);
      check_eq("coinc_step", bus16.rand_out, 16'h01FE);

      // Reset in the middle of a held draw.
      bus16.req = 1'b0;
      tick();
      bus16.req = 1'b1;
      tick();
      check_eq("rst_hold_valid", bus16.out_valid, 1'b1);
      rst = 1'b1;
      tick();
      check_eq("rst_mid_valid", bus16.out_valid, 1'b0);
      check_eq("rst_mid_rand", bus16.rand_out, 16'hACE1);
      check_eq("rst_mid_cnt", bus16.draw_cnt, 16'd0);
      rst = 1'b0;
      bus16.req = 1'b0;

      // Full period of the 8-bit instance.
      bus8.seed_load = 1'b1; bus8.seed_in = 8'h01;
      tick();
      check_eq("p8_seed", bus8.rand_out, 8'h01);
      bus8.seed_load = 1'b0;
      for (int i = 0; i < 256; i++) seen[i] = 1'b0;
      n_seen = 0;
      zero_hits = 0;
      tick();
      check_eq("p8_first", bus8.rand_out, 8'h02);
      for (int i = 0; i < 255; i++) begin
         if (i > 0) tick();
         if (bus8.rand_out == 8'h00) zero_hits = zero_hits + 1;
         if (!seen[bus8.rand_out]) begin
            seen[bus8.rand_out] = 1'b1;
            n_seen = n_seen + 1;
         end
      end
      check_eq("p8_return", bus8.rand_out, 8'h01);
      check_eq("p8_no_zero", zero_hits, 0);
      check_eq("p8_distinct", n_seen, 255);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
